// File: rtl/instr_fetch_unit.sv
// Fetch stage for a falling-edge-latched instruction ROM: owns the PC, captures
// returned words on the rising edge, and handles stall, redirect and halt.
module instr_fetch_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD = 32'hFC00_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] imem_address,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  output logic                  halted,
  output logic [1:0]            state_dbg
);

  // Handshake: instr_valid=1 marks a live (instr, instr_pc) pair; decode holds
  // it by raising stall, which freezes every fetch register until released.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_STALLED = 2'd2,
    S_HALTED  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   instr_pc_q, instr_pc_d;
  logic                    valid_q, valid_d;
  logic                    halted_q, halted_d;

  logic redirect;
  logic capture;
  logic is_halt;

  assign redirect = branch_taken && (state_q != S_HALTED);
  assign capture  = !branch_taken && !stall &&
                    ((state_q == S_FETCH) || (state_q == S_STALLED));
  assign is_halt  = (imem_data == HALT_WORD);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = S_FETCH;
      S_FETCH,
      S_STALLED: begin
        if (branch_taken)  state_d = S_FETCH;
        else if (stall)    state_d = S_STALLED;
        else if (is_halt)  state_d = S_HALTED;
        else               state_d = S_FETCH;
      end
      S_HALTED:  state_d = S_HALTED;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    if (redirect) begin
      // Wrong-path word in flight is dropped; target word arrives next cycle.
      pc_d    = branch_target;
      valid_d = 1'b0;
    end else if (capture) begin
      if (is_halt) begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end else begin
        instr_d    = imem_data;
        instr_pc_d = pc_q;
        valid_d    = 1'b1;
        pc_d       = pc_q + ADDR_WIDTH'(1);
      end
    end
  end

  assign imem_address = pc_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign instr_valid  = valid_q;
  assign halted       = halted_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural falling-edge ROM, directed scenarios,
// and a queue-based monitor that checks every newly presented instruction.
module tb_instr_fetch_unit;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [DW-1:0] HALT = 32'hFC00_0000;

  logic          clock;
  logic          reset;
  logic          stall;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic [AW-1:0] imem_address;
  logic [DW-1:0] imem_data;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          halted;
  logic [1:0]    state_dbg;

  logic [DW-1:0] rom [32];
  logic [AW+DW-1:0] exp_q[$];

  int vectors    = 0;
  int miscompares = 0;

  instr_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HALT_WORD(HALT)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_address(imem_address), .imem_data(imem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .halted(halted), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ROM latches on the falling edge
  initial imem_data = '0;
  always @(negedge clock) imem_data <= rom[imem_address];

  // monitor: one pop per newly presented instruction
  logic          last_valid = 1'b0;
  logic [AW-1:0] last_pc    = '0;
  always @(negedge clock) begin
    logic [AW+DW-1:0] e;
    if (instr_valid && (!last_valid || instr_pc != last_pc)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL capture: unexpected pc=%0d instr=%h, nothing expected", instr_pc, instr);
      end else begin
        e = exp_q.pop_front();
        if ({instr_pc, instr} !== e) begin
          miscompares++;
          $display("FAIL capture: got pc=%0d instr=%h, expected pc=%0d instr=%h",
                   instr_pc, instr, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
    if (instr_valid && halted) begin
      vectors++;
      miscompares++;
      $display("FAIL valid_while_halted: got valid=1 halted=1, expected not both");
    end
    last_valid = instr_valid;
    last_pc    = instr_pc;
  end

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [AW-1:0] pc);
    exp_q.push_back({pc, rom[pc]});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"},     64'(imem_address), 64'd0);
    check({tag, "_instr"},  64'(instr),        64'd0);
    check({tag, "_ipc"},    64'(instr_pc),     64'd0);
    check({tag, "_valid"},  64'(instr_valid),  64'd0);
    check({tag, "_halted"}, 64'(halted),       64'd0);
  endtask

  // from a fresh release: IDLE, captures 0..2, then halt on rom[3]
  task automatic run_to_halt(input string tag);
    expect_word(0); expect_word(1); expect_word(2);
    step();
    check({tag, "_idle_valid"}, 64'(instr_valid), 64'd0);
    repeat (4) step();
    check({tag, "_halted"}, 64'(halted), 64'd1);
    check({tag, "_halt_valid"}, 64'(instr_valid), 64'd0);
    check({tag, "_halt_addr"}, 64'(imem_address), 64'd3);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = '0;
    rom[0] = 32'h0022_0020;
    rom[1] = 32'h0022_0022;
    rom[2] = 32'h0022_0026;
    rom[3] = HALT;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

    // reset then free run
    step(); step();
    reset = 1'b0;
    check_reset_state("rst");
    run_to_halt("run");
    for (int i = 0; i < 10; i++) begin
      step();
      check("halt_hold_halted", 64'(halted), 64'd1);
      check("halt_hold_valid",  64'(instr_valid), 64'd0);
      check("halt_hold_addr",   64'(imem_address), 64'd3);
    end
    branch_taken = 1'b1; branch_target = 5'd7;
    step();
    branch_taken = 1'b0;
    check("halt_ignores_branch", 64'(imem_address), 64'd3);

    // reset while halted, then stall after the capture at pc 1
    reset = 1'b1; step(); reset = 1'b0;
    check_reset_state("rst_halt");
    expect_word(0); expect_word(1); expect_word(2);
    repeat (3) step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_instr", 64'(instr),        64'h0022_0022);
      check("stall_valid", 64'(instr_valid),  64'd1);
      check("stall_addr",  64'(imem_address), 64'd2);
    end
    stall = 1'b0;
    step();
    check("stall_release_ipc", 64'(instr_pc), 64'd2);
    step();
    check("stall_halted", 64'(halted), 64'd1);

    // redirect to 0 after the capture at pc 1
    reset = 1'b1; step(); reset = 1'b0;
    expect_word(0); expect_word(1);
    repeat (3) step();
    branch_taken = 1'b1; branch_target = 5'd0;
    step();
    branch_taken = 1'b0;
    check("redir_valid", 64'(instr_valid),  64'd0);
    check("redir_addr",  64'(imem_address), 64'd0);
    expect_word(0); expect_word(1); expect_word(2);
    repeat (4) step();
    check("redir_halted", 64'(halted), 64'd1);

    // branch over stall and wrap, then reset mid-stall
    rom[3] = '0;
    reset = 1'b1; step(); reset = 1'b0;
    expect_word(0);
    repeat (2) step();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 5'd31;
    step();
    branch_taken = 1'b0;
    check("bstall_addr",  64'(imem_address), 64'd31);
    check("bstall_valid", 64'(instr_valid),  64'd0);
    repeat (2) step();
    check("bstall_hold_addr",  64'(imem_address), 64'd31);
    check("bstall_hold_valid", 64'(instr_valid),  64'd0);
    expect_word(31);
    stall = 1'b0;
    step();
    check("wrap_addr", 64'(imem_address), 64'd0);
    expect_word(0);
    step();
    stall = 1'b1;
    repeat (2) step();
    check("mid_stall_addr",  64'(imem_address), 64'd1);
    check("mid_stall_instr", 64'(instr),        64'h0022_0020);
    rom[3] = HALT;
    reset = 1'b1; step(); reset = 1'b0; stall = 1'b0;
    check_reset_state("rst_stall");
    run_to_halt("rerun");

    step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
